// File: rtl/flex_pts_serializer_if.sv
// Handshake and serial-side signal bundle for flex_pts_serializer.
//   load_data    producer -> serializer  word to transmit
//   load_valid   producer -> serializer  load_data valid this cycle
//   load_ready   serializer -> producer  holding register empty
//   shift_strobe timing   -> serializer  one-clock pulse per bit period
//   abort        control  -> serializer  synchronous flush
//   serial_out   serializer -> line      bit stream, idles high
//   busy         serializer -> status    word held or being shifted
//   word_done    serializer -> status    pulse after the last bit of a word
interface flex_pts_serializer_if #(
    parameter int NUM_BITS = 8
);
    logic [NUM_BITS-1:0] load_data;
    logic                load_valid;
    logic                load_ready;
    logic                shift_strobe;
    logic                abort;
    logic                serial_out;
    logic                busy;
    logic                word_done;

    modport slave (
        input  load_data, load_valid, shift_strobe, abort,
        output load_ready, serial_out, busy, word_done
    );

    modport master (
        output load_data, load_valid, shift_strobe, abort,
        input  load_ready, serial_out, busy, word_done
    );
endinterface

// File: rtl/flex_pts_serializer.sv
// Parallel-to-serial transmitter with a one-word holding register so that
// back-to-back words stream without idle bits.
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    flex_pts_serializer_if.slave (load handshake, strobe, abort, outputs)
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high; moves a held word into the shifter on the next edge
// S_SHIFT | presenting shift_reg's output-end bit; advances on shift_strobe
module flex_pts_serializer #(
    parameter int NUM_BITS  = 8,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                  clk,
    input  logic                  n_rst,
    flex_pts_serializer_if.slave  bus
);
    localparam int CW = $clog2(NUM_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);
    localparam logic [NUM_BITS-1:0] ALL_ONES = {NUM_BITS{1'b1}};

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]          r_state;
    logic [NUM_BITS-1:0] r_hold;
    logic                r_hold_full;
    logic [NUM_BITS-1:0] r_shift;
    logic [CW-1:0]       r_bit_cnt;
    logic                r_word_done;

    logic                w_accept;
    logic                w_last;
    logic                w_tx_bit;
    logic [NUM_BITS-1:0] w_shifted;

    // Ready comes from the registered flag only, so a word can never be
    // accepted in the same cycle the holding register drains.
    assign w_accept  = bus.load_valid & ~r_hold_full;
    assign w_last    = (r_bit_cnt == LAST_BIT);
    assign w_tx_bit  = SHIFT_MSB ? r_shift[NUM_BITS-1] : r_shift[0];
    assign w_shifted = SHIFT_MSB ? {r_shift[NUM_BITS-2:0], 1'b1}
                                 : {1'b1, r_shift[NUM_BITS-1:1]};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_shift     <= ALL_ONES;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
        end else if (bus.abort) begin
            r_state     <= S_IDLE;
            r_hold_full <= 1'b0;
            r_shift     <= ALL_ONES;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;

            // Accept only happens with the hold empty, and the drains below
            // only happen with it full, so these never collide.
            if (w_accept) begin
                r_hold      <= bus.load_data;
                r_hold_full <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_hold_full <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bus.shift_strobe) begin
                        if (!w_last) begin
                            r_shift   <= w_shifted;
                            r_bit_cnt <= r_bit_cnt + CW'(1);
                        end else begin
                            r_word_done <= 1'b1;
                            r_bit_cnt   <= '0;
                            if (r_hold_full) begin
                                r_shift     <= r_hold;
                                r_hold_full <= 1'b0;
                            end else begin
                                r_shift <= ALL_ONES;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.load_ready = ~r_hold_full;
    assign bus.serial_out = (r_state == S_SHIFT) ? w_tx_bit : 1'b1;
    assign bus.busy       = (r_state == S_SHIFT) | r_hold_full;
    assign bus.word_done  = r_word_done;
endmodule

// File: tb/tb_flex_pts_serializer.sv
// Scoreboard bench for flex_pts_serializer: two instances (MSB-first and
// LSB-first). Expected bits are queued when a word is accepted and popped
// each time a strobe consumes the bit currently on serial_out.
module tb_flex_pts_serializer;
    logic clk;
    logic n_rst;

    flex_pts_serializer_if #(.NUM_BITS(8)) ifm ();
    flex_pts_serializer_if #(.NUM_BITS(8)) ifl ();

    flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b1)) dut_m (
        .clk(clk), .n_rst(n_rst), .bus(ifm.slave)
    );
    flex_pts_serializer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut_l (
        .clk(clk), .n_rst(n_rst), .bus(ifl.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit sb_q[$];
    int wd_m = 0;
    int wd_l = 0;

    always @(negedge clk) begin
        #2;
        if (ifm.word_done === 1'b1) wd_m++;
        if (ifl.word_done === 1'b1) wd_l++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_word(input bit sel, input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            sb_q.push_back(sel ? d[i] : d[7-i]);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic drive_load(input bit sel, input logic [7:0] d);
        bit done = 1'b0;
        if (sel) begin ifl.load_data = d; ifl.load_valid = 1'b1; end
        else     begin ifm.load_data = d; ifm.load_valid = 1'b1; end
        for (int i = 0; i < 64 && !done; i++) begin
            if ((sel ? ifl.load_ready : ifm.load_ready) === 1'b1) begin
                push_word(sel, d);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (sel) ifl.load_valid = 1'b0; else ifm.load_valid = 1'b0;
        if (!done) chk("load_timeout", 0, 1);
    endtask

    task automatic do_strobe(input bit sel, input int gap);
        logic so;
        repeat (gap) @(negedge clk);
        so = sel ? ifl.serial_out : ifm.serial_out;
        if (sb_q.size() == 0) chk("sb_empty", 0, 1);
        else                  chk(sel ? "bit_lsb" : "bit_msb", so, sb_q.pop_front());
        if (sel) ifl.shift_strobe = 1'b1; else ifm.shift_strobe = 1'b1;
        @(negedge clk);
        if (sel) ifl.shift_strobe = 1'b0; else ifm.shift_strobe = 1'b0;
    endtask

    logic [7:0] w4 [4] = '{8'hFF, 8'h00, 8'hA5, 8'h5A};

    initial begin
        int wd0, idx, start, span;
        bit acc, fin;

        ifm.load_data = '0; ifm.load_valid = 0; ifm.shift_strobe = 0; ifm.abort = 0;
        ifl.load_data = '0; ifl.load_valid = 0; ifl.shift_strobe = 0; ifl.abort = 0;
        n_rst = 1'b0;
        #1;
        chk("rst_so",    ifm.serial_out, 1);
        chk("rst_ready", ifm.load_ready, 1);
        chk("rst_busy",  ifm.busy,       0);
        chk("rst_wd",    ifm.word_done,  0);
        chk("rst_so_l",  ifl.serial_out, 1);
        @(negedge clk); @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // 1: MSB first, A5, strobe every 4 clk
        wd0 = wd_m;
        drive_load(0, 8'hA5);
        chk("t1_ready_held", ifm.load_ready, 0);
        chk("t1_busy_held",  ifm.busy,       1);
        chk("t1_so_xfer",    ifm.serial_out, 1);
        for (int i = 0; i < 8; i++) do_strobe(0, 3);
        chk("t1_wd_pulse", ifm.word_done,  1);
        chk("t1_so_idle",  ifm.serial_out, 1);
        chk("t1_busy",     ifm.busy,       0);
        @(negedge clk);
        chk("t1_wd_clear", ifm.word_done, 0);
        chk("t1_wd_count", wd_m - wd0, 1);

        // 2: LSB first, 01; strobe during the IDLE->SHIFT transfer is ignored
        wd0 = wd_l;
        drive_load(1, 8'h01);
        ifl.shift_strobe = 1'b1;
        @(negedge clk);
        ifl.shift_strobe = 1'b0;
        for (int i = 0; i < 8; i++) do_strobe(1, 1);
        chk("t2_so_idle", ifl.serial_out, 1);
        chk("t2_busy",    ifl.busy,       0);
        @(negedge clk);
        chk("t2_wd_count", wd_l - wd0, 1);
        chk("t2_q_empty", sb_q.size(), 0);

        // 3: 3C then C3 loaded during bit 2 -> gapless 16 bits
        wd0 = wd_m;
        drive_load(0, 8'h3C);
        do_strobe(0, 1);
        do_strobe(0, 1);
        drive_load(0, 8'hC3);
        chk("t3_ready_after_acc", ifm.load_ready, 0);
        for (int i = 0; i < 5; i++) do_strobe(0, 1);
        @(negedge clk);
        chk("t3_ready_before_last", ifm.load_ready, 0);
        do_strobe(0, 0);
        chk("t3_wd_first",    ifm.word_done,  1);
        chk("t3_ready_reload", ifm.load_ready, 1);
        chk("t3_busy_reload", ifm.busy,       1);
        for (int i = 0; i < 8; i++) do_strobe(0, 0);
        chk("t3_so_idle", ifm.serial_out, 1);
        @(negedge clk);
        chk("t3_wd_count", wd_m - wd0, 2);

        // 4: strobe and valid held high, 1 bit/clk sustained
        wd0 = wd_m; idx = 0; start = -1; span = 0; fin = 1'b0;
        ifm.load_data = w4[0]; ifm.load_valid = 1'b1;
        for (int c = 0; c < 200 && !fin; c++) begin
            acc = (ifm.load_valid === 1'b1) && (ifm.load_ready === 1'b1);
            if (acc) begin
                push_word(0, ifm.load_data);
                if (start < 0) start = c + 2;
            end
            if (start >= 0 && c >= start && sb_q.size() > 0) begin
                chk("t4_bit", ifm.serial_out, sb_q.pop_front());
                chk("t4_busy", ifm.busy, 1);
                ifm.shift_strobe = 1'b1;
                span++;
            end else begin
                ifm.shift_strobe = 1'b0;
            end
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 4) ifm.load_data = w4[idx];
                else         ifm.load_valid = 1'b0;
            end
            if (start >= 0 && idx == 4 && sb_q.size() == 0) begin
                fin = 1'b1;
                chk("t4_span", c - start + 1, 32);
            end
        end
        ifm.shift_strobe = 1'b0;
        ifm.load_valid   = 1'b0;
        if (!fin) chk("t4_timeout", 0, 1);
        chk("t4_bits", span, 32);
        @(negedge clk);
        chk("t4_wd_count", wd_m - wd0, 4);
        chk("t4_busy_end", ifm.busy, 0);

        // 5: abort during bit 4 with hold full
        wd0 = wd_m;
        drive_load(0, 8'h3C);
        for (int i = 0; i < 4; i++) do_strobe(0, 1);
        drive_load(0, 8'h81);
        chk("t5_hold_full", ifm.load_ready, 0);
        ifm.abort = 1'b1; ifm.load_valid = 1'b1; ifm.load_data = 8'hEE;
        @(negedge clk);
        ifm.abort = 1'b0; ifm.load_valid = 1'b0;
        sb_q.delete();
        chk("t5_so",    ifm.serial_out, 1);
        chk("t5_ready", ifm.load_ready, 1);
        chk("t5_busy",  ifm.busy,       0);
        chk("t5_wd",    ifm.word_done,  0);
        ifm.shift_strobe = 1'b1;
        repeat (3) @(negedge clk);
        ifm.shift_strobe = 1'b0;
        chk("t5_so_idle_strobe", ifm.serial_out, 1);
        chk("t5_busy_later",     ifm.busy,       0);
        chk("t5_wd_count", wd_m - wd0, 0);

        // 6: async reset during bit 3, then 81 transmits normally
        wd0 = wd_m;
        drive_load(0, 8'h5A);
        for (int i = 0; i < 3; i++) do_strobe(0, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("t6_so",    ifm.serial_out, 1);
        chk("t6_ready", ifm.load_ready, 1);
        chk("t6_busy",  ifm.busy,       0);
        @(negedge clk);
        n_rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk("t6_wd_none", wd_m - wd0, 0);
        drive_load(0, 8'h81);
        for (int i = 0; i < 8; i++) do_strobe(0, 1);
        chk("t6_so_idle", ifm.serial_out, 1);
        chk("t6_busy_end", ifm.busy, 0);
        @(negedge clk);
        chk("t6_wd_count", wd_m - wd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
